// File: rtl/scan_sequencer.sv
// Scan sequencer: walks the enabled channels of an 8-way decoder, holding each for div+1 cycles.
// Supports continuous scanning with a wrap pulse, or a single sweep ending in a done pulse.
module scan_sequencer #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [DIV_W-1:0] div,
    input  logic [7:0]       mask,
    output logic [2:0]       A,
    output logic             E,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic {StIdle, StRun} state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [7:0]       mask_q, mask_d;
    logic [2:0]       a_d;
    logic             e_d, busy_d, done_d, wrap_d;
    logic [7:0]       above;

    function automatic logic [2:0] lowest(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Enabled channels strictly above the current one; empty when A is the top channel.
    assign above = mask_q & ~((8'd2 << A) - 8'd1);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        div_d   = div_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        a_d     = A;
        e_d     = E;
        busy_d  = busy;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start && !stop && (mask != 8'd0)) begin
                    state_d = StRun;
                    mode_d  = mode;
                    div_d   = div;
                    mask_d  = mask;
                    cnt_d   = '0;
                    a_d     = lowest(mask);
                    e_d     = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    e_d     = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_q == div_q) begin
                    cnt_d = '0;
                    if (|above) begin
                        a_d = lowest(above);
                    end else if (mode_q) begin
                        state_d = StIdle;
                        e_d     = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        a_d    = lowest(mask_q);
                        wrap_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mode_q  <= 1'b0;
            div_q   <= '0;
            mask_q  <= 8'd0;
            cnt_q   <= '0;
            A       <= 3'd0;
            E       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            A       <= a_d;
            E       <= e_d;
            busy    <= busy_d;
            done    <= done_d;
            wrap    <= wrap_d;
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: expected per-cycle outputs are queued with the stimulus
// and popped one per clock as the sequencer produces them.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] div = 8'd0;
    logic [7:0] mask = 8'd0;
    logic [2:0] A;
    logic       E, busy, done, wrap;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [6:0] v;  // {A, E, busy, done, wrap}
        string      tag;
    } exp_t;

    exp_t q[$];

    scan_sequencer #(.DIV_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .stop (stop),
        .mode (mode),
        .div  (div),
        .mask (mask),
        .A    (A),
        .E    (E),
        .busy (busy),
        .done (done),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [2:0] a, input logic e, input logic b, input logic d,
                        input logic w, input string tag);
        exp_t x;
        x.v   = {a, e, b, d, w};
        x.tag = tag;
        q.push_back(x);
    endtask

    task automatic check(input logic [6:0] want, input string tag);
        logic [6:0] got;
        got = {A, E, busy, done, wrap};
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got A/E/busy/done/wrap=%b want %b", tag, got, want);
        end
    endtask

    // One expected entry per clock; start/stop are single-cycle requests.
    task automatic drain();
        exp_t x;
        while (q.size() > 0) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            stop  = 1'b0;
            x = q.pop_front();
            check(x.v, x.tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        check(7'b000_0000, "reset");
        rst = 1'b0;
        push(3'd0, 0, 0, 0, 0, "idle_after_reset");
        drain();

        // Single sweep, all channels, two cycles each.
        mode = 1'b1; div = 8'd1; mask = 8'hFF; start = 1'b1;
        for (int ch = 0; ch < 8; ch++) begin
            push(3'(ch), 1, 1, 0, 0, "sweep_ch");
            push(3'(ch), 1, 1, 0, 0, "sweep_ch");
        end
        push(3'd7, 0, 0, 1, 0, "sweep_done");
        push(3'd7, 0, 0, 0, 0, "sweep_done_one_cycle");
        drain();

        // Continuous, div=0, sparse mask 2,5,7.
        mode = 1'b0; div = 8'd0; mask = 8'b1010_0100; start = 1'b1;
        push(3'd2, 1, 1, 0, 0, "cont_first");
        for (int s = 0; s < 2; s++) begin
            push(3'd5, 1, 1, 0, 0, "cont_5");
            push(3'd7, 1, 1, 0, 0, "cont_7");
            push(3'd2, 1, 1, 0, 1, "cont_wrap_2");
        end
        push(3'd5, 1, 1, 0, 0, "cont_5_last");
        drain();
        stop = 1'b1;
        push(3'd5, 0, 0, 0, 0, "cont_stop");
        drain();
        start = 1'b1; stop = 1'b1;
        push(3'd5, 0, 0, 0, 0, "start_stop_idle");
        push(3'd5, 0, 0, 0, 0, "start_stop_idle2");
        drain();

        // Continuous div=3; stop on A=4's expiry cycle must win over advancing.
        div = 8'd3; mask = 8'hFF; start = 1'b1;
        for (int ch = 0; ch < 5; ch++) begin
            for (int k = 0; k < 4; k++) push(3'(ch), 1, 1, 0, 0, "dwell3");
        end
        drain();
        stop = 1'b1;
        push(3'd4, 0, 0, 0, 0, "stop_priority");
        drain();
        mask = 8'h00; start = 1'b1;
        push(3'd4, 0, 0, 0, 0, "zero_mask_start");
        push(3'd4, 0, 0, 0, 0, "zero_mask_idle");
        drain();

        // Single channel continuous: wrap every 3 cycles; later input changes ignored.
        div = 8'd2; mask = 8'h10; start = 1'b1;
        push(3'd4, 1, 1, 0, 0, "one_ch");
        push(3'd4, 1, 1, 0, 0, "one_ch");
        push(3'd4, 1, 1, 0, 0, "one_ch");
        push(3'd4, 1, 1, 0, 1, "one_ch_wrap");
        push(3'd4, 1, 1, 0, 0, "one_ch");
        push(3'd4, 1, 1, 0, 0, "one_ch");
        drain();
        mask = 8'hFF; mode = 1'b1; div = 8'd0; start = 1'b1;
        push(3'd4, 1, 1, 0, 1, "ignore_changes_wrap");
        push(3'd4, 1, 1, 0, 0, "ignore_changes");
        push(3'd4, 1, 1, 0, 0, "ignore_changes");
        push(3'd4, 1, 1, 0, 1, "ignore_changes_wrap2");
        drain();
        stop = 1'b1;
        push(3'd4, 0, 0, 0, 0, "one_ch_stop");
        drain();

        // Asynchronous reset mid-scan at A=5.
        mode = 1'b0; div = 8'd1; mask = 8'hFF; start = 1'b1;
        for (int ch = 0; ch < 5; ch++) begin
            push(3'(ch), 1, 1, 0, 0, "pre_rst");
            push(3'(ch), 1, 1, 0, 0, "pre_rst");
        end
        push(3'd5, 1, 1, 0, 0, "pre_rst_5");
        drain();
        #2;
        rst = 1'b1;
        #1;
        check(7'b000_0000, "async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(3'd0, 0, 0, 0, 0, "post_rst_idle");
        push(3'd0, 0, 0, 0, 0, "post_rst_idle");
        push(3'd0, 0, 0, 0, 0, "post_rst_idle");
        drain();

        // Single sweep over only the top channel, one-cycle dwell.
        mode = 1'b1; div = 8'd0; mask = 8'h80; start = 1'b1;
        push(3'd7, 1, 1, 0, 0, "top_only");
        push(3'd7, 0, 0, 1, 0, "top_only_done");
        push(3'd7, 0, 0, 0, 0, "top_only_idle");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
